// File: rtl/div_pkg.sv
// div_pkg: shared encodings and default sizes for the SIMT divergence controller
// Contents: branch op encodings, controller FSM states, default parameters.
package div_pkg;
  localparam int N_CORES_DEF = 4;
  localparam int STACK_DEPTH_DEF = 3;
  localparam int PC_W_DEF = 8;
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_IF    = 2'b01,
    OP_ELSE  = 2'b10,
    OP_ENDIF = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_ELSE_PUSH,
    S_CHK
  } state_e;
endpackage

// File: rtl/div_cond_file.sv
// div_cond_file: per-nesting-level store of {parent_full, cond}
// Ports: clk, reset (async, active-high), we/waddr/wdata write port,
//        raddr/rdata combinational read port.
module div_cond_file #(
  parameter int W = 5,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**D];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < 2**D; i++) mem[i] <= '0;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/simt_div_ctrl.sv
// simt_div_ctrl: decodes IF/ELSE/ENDIF into predicate mask stack commands
// Ports: clk, reset (async, active-high); instr_valid/instr_ready/op/cond/
//        else_pc/endif_pc instruction side; stk_d_in/push/pop/comp commands
//        and stk_tos/all_true/all_false feedback; active_mask, pc_load/
//        pc_target redirect, depth, sticky nest_err.
// Config: DIVSKIP_EN enables the PC redirect over bodies with no active lane.
module simt_div_ctrl
  import div_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int PC_W = PC_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [1:0]             op,
  input  logic [N_CORES-1:0]     cond,
  input  logic [PC_W-1:0]        else_pc,
  input  logic [PC_W-1:0]        endif_pc,
  output logic [N_CORES-1:0]     stk_d_in,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_comp,
  input  logic [N_CORES-1:0]     stk_tos,
  input  logic                   stk_all_true,
  input  logic                   stk_all_false,
  output logic [N_CORES-1:0]     active_mask,
  output logic                   pc_load,
  output logic [PC_W-1:0]        pc_target,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   nest_err
);
`ifdef DIVSKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [STACK_DEPTH-1:0] MAX_D = '1;
  state_e state, state_n;
  logic [STACK_DEPTH-1:0] depth_n;
  logic [PC_W-1:0] target, target_n;
  logic err_set, accept, cf_we, parent_full;
  logic [N_CORES:0] cf_rdata;
  logic [N_CORES-1:0] cur_cond;
  div_cond_file #(.W(N_CORES + 1), .D(STACK_DEPTH)) u_cond (
    .clk  (clk),
    .reset(reset),
    .we   (cf_we),
    .waddr(depth + STACK_DEPTH'(1)),
    .wdata({stk_all_true, cond}),
    .raddr(depth),
    .rdata(cf_rdata)
  );
  assign cur_cond = cf_rdata[N_CORES-1:0];
  assign parent_full = cf_rdata[N_CORES];
  assign instr_ready = state == S_IDLE;
  assign accept = instr_valid && instr_ready;
  assign active_mask = stk_tos;
  assign pc_load = SKIP_EN && state == S_CHK && stk_all_false;
  assign pc_target = pc_load ? target : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      depth <= '0;
      target <= '0;
      nest_err <= 1'b0;
    end else begin
      state <= state_n;
      depth <= depth_n;
      target <= target_n;
      nest_err <= nest_err | err_set;
    end
  always_comb begin
    state_n = state;
    depth_n = depth;
    target_n = target;
    err_set = 1'b0;
    cf_we = 1'b0;
    stk_push = 1'b0;
    stk_pop = 1'b0;
    stk_comp = 1'b0;
    stk_d_in = '0;
    case (state)
      S_IDLE:
        if (accept)
          case (op)
            OP_IF:
              if (depth != MAX_D) begin
                stk_push = 1'b1;
                stk_d_in = stk_tos & cond;
                cf_we = 1'b1;
                depth_n = depth + STACK_DEPTH'(1);
                state_n = S_CHK;
                target_n = else_pc;
              end else err_set = 1'b1;
            // a full parent lets the top be inverted in place; otherwise
            // the parent must be exposed again to mask the else lanes
            OP_ELSE:
              if (depth != '0) begin
                stk_comp = parent_full;
                stk_pop = !parent_full;
                state_n = parent_full ? S_CHK : S_ELSE_PUSH;
                target_n = endif_pc;
              end else err_set = 1'b1;
            OP_ENDIF:
              if (depth != '0) begin
                stk_pop = 1'b1;
                depth_n = depth - STACK_DEPTH'(1);
              end else err_set = 1'b1;
            default: ;
          endcase
      S_ELSE_PUSH: begin
        stk_push = 1'b1;
        stk_d_in = stk_tos & ~cur_cond;
        state_n = S_CHK;
      end
      S_CHK: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_simt_div_ctrl.sv
// tb_simt_div_ctrl: table-driven scoreboard bench for simt_div_ctrl
module tb_simt_div_ctrl;
  import div_pkg::*;
`ifdef DIVSKIP_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  typedef struct packed {
    logic [1:0] k;
    logic [7:0] d;
  } cmd_t;
  typedef struct {
    bit         rst;
    logic [3:0] root;
    op_e        op;
    logic [3:0] cond;
    logic [7:0] epc;
    logic [7:0] ipc;
    int         cyc;
    int         n;
    cmd_t       c [3];
    logic [2:0] dep;
    logic       err;
    logic [3:0] tos;
  } vec_t;
  localparam cmd_t C_NONE = '{k: 2'd0, d: 8'h00};
  localparam cmd_t C_POP  = '{k: 2'd1, d: 8'h00};
  localparam cmd_t C_COMP = '{k: 2'd2, d: 8'h00};
  logic clk = 1'b0;
  logic reset;
  logic instr_valid, instr_ready;
  logic [1:0] op;
  logic [3:0] cond, stk_d_in, stk_tos, active_mask;
  logic [7:0] else_pc, endif_pc, pc_target;
  logic stk_push, stk_pop, stk_comp, stk_all_true, stk_all_false, pc_load, nest_err;
  logic [2:0] depth;
  int checks = 0;
  int errors = 0;
  cmd_t exp_q[$];
  vec_t tbl[$];
  logic [3:0] stk_m [8];
  int sp;
  logic [3:0] root_m = 4'hF;
  always #5 clk = ~clk;
  simt_div_ctrl #(.N_CORES(4), .STACK_DEPTH(3), .PC_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .op           (op),
    .cond         (cond),
    .else_pc      (else_pc),
    .endif_pc     (endif_pc),
    .stk_d_in     (stk_d_in),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_comp     (stk_comp),
    .stk_tos      (stk_tos),
    .stk_all_true (stk_all_true),
    .stk_all_false(stk_all_false),
    .active_mask  (active_mask),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .depth        (depth),
    .nest_err     (nest_err)
  );
  always @(posedge clk or posedge reset)
    if (reset) begin
      sp <= 0;
      stk_m[0] <= root_m;
    end else if (stk_push && sp < 7) begin
      stk_m[sp+1] <= stk_d_in;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0)
      sp <= sp - 1;
    else if (stk_comp)
      stk_m[sp] <= ~stk_m[sp];
  assign stk_tos = stk_m[sp];
  assign stk_all_true = &stk_tos;
  assign stk_all_false = ~|stk_tos;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic sb(logic [1:0] k, logic [7:0] d);
    cmd_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb unexpected cmd %0d data %h, none wanted", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k !== k || e.d !== d) begin
        errors++;
        $display("FAIL sb got cmd %0d data %h want cmd %0d data %h", k, d, e.k, e.d);
      end
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      chk("cmd_exclusive", 32'($countones({stk_push, stk_pop, stk_comp}) > 1), 0);
      if (stk_push) sb(2'd0, {4'h0, stk_d_in});
      if (stk_pop) sb(2'd1, 8'h00);
      if (stk_comp) sb(2'd2, 8'h00);
      if (pc_load) sb(2'd3, pc_target);
    end
  function automatic cmd_t cp(logic [3:0] d);
    return '{k: 2'd0, d: {4'h0, d}};
  endfunction
  function automatic cmd_t cl(logic [7:0] d);
    return '{k: 2'd3, d: d};
  endfunction
  function automatic vec_t mk(bit r, logic [3:0] root, op_e o, logic [3:0] c, logic [7:0] epc,
                              logic [7:0] ipc, int cyc, int n, cmd_t a, cmd_t b, cmd_t cc,
                              logic [2:0] dep, logic err, logic [3:0] tos);
    vec_t v;
    v.rst = r; v.root = root; v.op = o; v.cond = c; v.epc = epc; v.ipc = ipc;
    v.cyc = cyc; v.n = n; v.c[0] = a; v.c[1] = b; v.c[2] = cc;
    v.dep = dep; v.err = err; v.tos = tos;
    return v;
  endfunction
  task automatic do_reset(logic [3:0] root);
    instr_valid = 1'b0;
    root_m = root;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(vec_t v);
    int n;
    if (v.rst) do_reset(v.root);
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.c[i]);
    op = v.op;
    cond = v.cond;
    else_pc = v.epc;
    endif_pc = v.ipc;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 1;
    while (!instr_ready && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("cycles", n, v.cyc);
    chk("depth", depth, v.dep);
    chk("nest_err", nest_err, v.err);
    chk("mask", active_mask, v.tos);
    chk("sb_left", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    op = 2'b00;
    cond = '0;
    else_pc = '0;
    endif_pc = '0;
    tbl.push_back(mk(0, 4'hF, OP_NOP,   4'h0, 8'h00, 8'h00, 1, 0, C_NONE, C_NONE, C_NONE, 0, 0, 4'hF));
    tbl.push_back(mk(0, 4'hF, OP_IF,    4'h5, 8'h10, 8'h00, 2, 1, cp(4'h5), C_NONE, C_NONE, 1, 0, 4'h5));
    tbl.push_back(mk(0, 4'hF, OP_ELSE,  4'h0, 8'h00, 8'h18, 2, 1, C_COMP, C_NONE, C_NONE, 1, 0, 4'hA));
    tbl.push_back(mk(0, 4'hF, OP_ENDIF, 4'h0, 8'h00, 8'h00, 1, 1, C_POP, C_NONE, C_NONE, 0, 0, 4'hF));
    tbl.push_back(mk(0, 4'hF, OP_IF,    4'h0, 8'h20, 8'h00, 2, 1 + SK, cp(4'h0), cl(8'h20), C_NONE, 1, 0, 4'h0));
    tbl.push_back(mk(0, 4'hF, OP_ENDIF, 4'h0, 8'h00, 8'h00, 1, 1, C_POP, C_NONE, C_NONE, 0, 0, 4'hF));
    tbl.push_back(mk(0, 4'hF, OP_ELSE,  4'h0, 8'h00, 8'h30, 1, 0, C_NONE, C_NONE, C_NONE, 0, 1, 4'hF));
    tbl.push_back(mk(1, 4'hF, OP_ENDIF, 4'h0, 8'h00, 8'h00, 1, 0, C_NONE, C_NONE, C_NONE, 0, 1, 4'hF));
    tbl.push_back(mk(0, 4'hF, OP_NOP,   4'h0, 8'h00, 8'h00, 1, 0, C_NONE, C_NONE, C_NONE, 0, 1, 4'hF));
    tbl.push_back(mk(1, 4'h6, OP_IF,    4'h3, 8'h11, 8'h00, 2, 1, cp(4'h2), C_NONE, C_NONE, 1, 0, 4'h2));
    tbl.push_back(mk(0, 4'h6, OP_ELSE,  4'h0, 8'h00, 8'h40, 3, 2, C_POP, cp(4'h4), C_NONE, 1, 0, 4'h4));
    tbl.push_back(mk(0, 4'h6, OP_ENDIF, 4'h0, 8'h00, 8'h00, 1, 1, C_POP, C_NONE, C_NONE, 0, 0, 4'h6));
    tbl.push_back(mk(1, 4'hF, OP_IF,    4'hF, 8'h12, 8'h00, 2, 1, cp(4'hF), C_NONE, C_NONE, 1, 0, 4'hF));
    tbl.push_back(mk(0, 4'hF, OP_ELSE,  4'h0, 8'h00, 8'h33, 2, 1 + SK, C_COMP, cl(8'h33), C_NONE, 1, 0, 4'h0));
    tbl.push_back(mk(1, 4'hF, OP_IF,    4'hF, 8'h01, 8'h00, 2, 1, cp(4'hF), C_NONE, C_NONE, 1, 0, 4'hF));
    for (int i = 2; i <= 7; i++)
      tbl.push_back(mk(0, 4'hF, OP_IF, 4'hF, 8'h01, 8'h00, 2, 1, cp(4'hF), C_NONE, C_NONE, 3'(i), 0, 4'hF));
    tbl.push_back(mk(0, 4'hF, OP_IF,    4'h1, 8'h01, 8'h00, 1, 0, C_NONE, C_NONE, C_NONE, 7, 1, 4'hF));
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_err", nest_err, 0);
    chk("rst_cmds", {stk_push, stk_pop, stk_comp}, 0);
    chk("rst_d_in", stk_d_in, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_target", pc_target, 0);
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);
    apply(mk(1, 4'h6, OP_IF, 4'h3, 8'h11, 8'h00, 2, 1, cp(4'h2), C_NONE, C_NONE, 1, 0, 4'h2));
    exp_q.push_back(C_POP);
    op = OP_ELSE;
    endif_pc = 8'h44;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk("ep_state", {instr_ready, stk_push}, 2'b01);
    chk("ep_sb_pop", exp_q.size(), 0);
    root_m = 4'h6;
    reset = 1'b1;
    #1;
    chk("ep_rst_push", stk_push, 0);
    chk("ep_rst_ready", instr_ready, 1);
    chk("ep_rst_depth", depth, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("ep_post_depth", depth, 0);
    chk("ep_post_ready", instr_ready, 1);
    chk("ep_post_mask", active_mask, 4'h6);
    @(posedge clk);
    #1;
    chk("ep_post_cmds", {stk_push, stk_pop, stk_comp, pc_load}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simt_div_ctrl.md
# simt_div_ctrl

Divergence controller for the SM core scheduler. It decodes structured branch instructions (IF/ELSE/ENDIF) carrying per-lane condition bits and issues push/pop/complement commands to the predicate mask stack. It reads back the stack's top-of-stack and all-true/all-false flags. Optionally, it redirects the PC past a branch body when no lane is active.

## Interface
- N_CORES, 4, lanes per SM; width of masks
- STACK_DEPTH, 3, log2 of mask-stack entries; max nesting depth is 2^STACK_DEPTH-1
- PC_W, 8, program-counter width

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- instr_valid  in  1  branch instruction offered
- instr_ready  out  1  controller idle, accepts instruction this cycle
- op  in  2  00 NOP, 01 IF, 10 ELSE, 11 ENDIF
- cond  in  N_CORES  per-lane condition result (IF only)
- else_pc  in  PC_W  target when IF body is fully skipped
- endif_pc  in  PC_W  target when ELSE body is fully skipped
- stk_d_in  out  N_CORES  mask to push
- stk_push / stk_pop / stk_comp  out  1 each  stack commands, mutually exclusive
- stk_tos  in  N_CORES  current top-of-stack, registered, updated at each edge
- stk_all_true / stk_all_false  in  1  flags for current top
- active_mask  out  N_CORES  equals stk_tos
- pc_load  out  1  one-cycle PC redirect strobe
- pc_target  out  PC_W  redirect target, valid with pc_load
- depth  out  STACK_DEPTH  current nesting level
- nest_err  out  1  sticky over/underflow flag

## Operation
- Accept = instr_valid & instr_ready. instr_ready=1 only in IDLE.
- States: IDLE, ELSE_PUSH, CHK.
- Per-level cond file, indexed by depth. Each entry holds cond[N_CORES] and the parent_full bit.
- NOP: consumed, no effect.
- IF, depth < 2^STACK_DEPTH-1:
  - In the accept cycle, assert stk_push with stk_d_in = stk_tos & cond.
  - Write cond and parent_full=stk_all_true to entry depth+1. Increment depth.
  - Go to CHK with target=else_pc.
- IF at max depth: no push, nest_err=1, stay IDLE.
- ELSE, depth ≥ 1:
  - If parent_full[depth] is set: assert stk_comp in the accept cycle, then go to CHK with target=endif_pc.
  - Otherwise: assert stk_pop in the accept cycle and go to ELSE_PUSH. In ELSE_PUSH, assert stk_push with stk_d_in = stk_tos & ~cond[depth], then go to CHK with target=endif_pc.
  - depth is unchanged in both paths.
- ELSE at depth 0: nest_err=1, no command.
- ENDIF, depth ≥ 1: assert stk_pop, decrement depth, stay IDLE.
- ENDIF at depth 0: nest_err=1, no pop.
- CHK:
  - If stk_all_false (and the skip feature is enabled), pulse pc_load with pc_target=target.
  - Always return to IDLE.
- nest_err is cleared only by reset.

## Timing
- Reset values:
  - State IDLE, depth 0, nest_err 0, cond file cleared.
  - pc_load 0, pc_target 0, all stk_* commands 0, stk_d_in 0.
  - instr_ready 1 after reset deasserts.
- Stack commands are combinational from the accept cycle / current state and take effect at the next edge.
- Occupancy per instruction:
  - IF: 2 cycles (accept + CHK).
  - ELSE, complement path: 2 cycles.
  - ELSE, pop/push path: 3 cycles.
  - ENDIF, NOP, error cases: 1 cycle.
- pc_load is asserted only in CHK and only for one cycle.
- instr_valid while busy is ignored; the source holds it until accepted.
- Reset mid-operation aborts to IDLE with no pending command. The stack shares the same reset.

## Configuration
- DIVSKIP_EN defined: CHK raises pc_load when stk_all_false.
- DIVSKIP_EN undefined: pc_load and pc_target are tied 0. The CHK state is still traversed, so cycle counts are identical and bodies execute under an empty mask.

## Structure
- Package div_pkg holds:
  - op encodings (OP_NOP/IF/ELSE/ENDIF)
  - state encoding
  - N_CORES and STACK_DEPTH defaults
- Sub-module div_cond_file: 2^STACK_DEPTH × (N_CORES+1) register file with async reset, one write port, one read port indexed by depth.

## Test plan
- Reset: instr_ready=1, depth=0, nest_err=0, no stk_* asserted, pc_load=0.
- tos=1111, IF cond=0101: stk_push with d_in=0101 in the accept cycle; depth=1; instr_ready low one cycle; no pc_load.
- Then ELSE (parent_full=1): single stk_comp, top becomes 1010. Nested case with tos=0110, IF cond=0011 then ELSE: push 0010, then pop, then push 0100.
- tos=1111, IF cond=0000, else_pc=0x20:
  - With DIVSKIP_EN: pc_load=1 and pc_target=0x20 in the CHK cycle.
  - Without it: pc_load stays 0.
- ENDIF at depth 0: no pop, nest_err=1 and sticky. IF at depth 7: no push, nest_err=1.
- Reset asserted in ELSE_PUSH: no push issued, state IDLE, depth=0 next cycle.
